// File: rtl/mc_main_controller.sv
// Sequencing FSM and ALU decoder for a multi-cycle MIPS datapath with a single
// unified memory. Control outputs are decoded from the current state and IR fields.
module mc_main_controller (
  input  logic       clk,
  input  logic       reset,
  input  logic [5:0] opcode,
  input  logic [5:0] funct,
  input  logic       mem_ready,
  output logic       pc_write,
  output logic       branch,
  output logic       iord,
  output logic       mem_read,
  output logic       mem_write,
  output logic       ir_write,
  output logic       reg_write,
  output logic       reg_dst,
  output logic       mem_to_reg,
  output logic [1:0] alu_src_a,
  output logic [1:0] alu_src_b,
  output logic [1:0] pc_src,
  output logic [3:0] alu_ctrl,
  output logic       instr_done,
  output logic       illegal_instr,
  output logic [3:0] state_dbg
);

  localparam logic [3:0] S_FETCH  = 4'd0;
  localparam logic [3:0] S_DECODE = 4'd1;
  localparam logic [3:0] S_MEMADR = 4'd2;
  localparam logic [3:0] S_MEMRD  = 4'd3;
  localparam logic [3:0] S_MEMWB  = 4'd4;
  localparam logic [3:0] S_MEMWR  = 4'd5;
  localparam logic [3:0] S_EXEC_R = 4'd6;
  localparam logic [3:0] S_ALUWB  = 4'd7;
  localparam logic [3:0] S_BRANCH = 4'd8;
  localparam logic [3:0] S_IEXEC  = 4'd9;
  localparam logic [3:0] S_IWB    = 4'd10;
  localparam logic [3:0] S_JUMP   = 4'd11;

  localparam logic [3:0] ALU_ADD  = 4'd0;
  localparam logic [3:0] ALU_SUB  = 4'd1;
  localparam logic [3:0] ALU_SLT  = 4'd2;
  localparam logic [3:0] ALU_SLTU = 4'd3;
  localparam logic [3:0] ALU_SLL  = 4'd4;
  localparam logic [3:0] ALU_SRL  = 4'd5;
  localparam logic [3:0] ALU_SRA  = 4'd6;
  localparam logic [3:0] ALU_AND  = 4'd7;
  localparam logic [3:0] ALU_OR   = 4'd8;

  localparam logic [5:0] OP_RTYPE = 6'h00;
  localparam logic [5:0] OP_J     = 6'h02;
  localparam logic [5:0] OP_BEQ   = 6'h04;
  localparam logic [5:0] OP_ADDI  = 6'h08;
  localparam logic [5:0] OP_ADDIU = 6'h09;
  localparam logic [5:0] OP_LW    = 6'h23;
  localparam logic [5:0] OP_SW    = 6'h2B;

  logic [3:0] state_q, state_d;
  logic       r_legal;
  logic       r_shamt;
  logic [3:0] r_alu;

  // R-type funct decode; the immediate shifts take their amount from shamt.
  always_comb begin
    r_legal = 1'b1;
    r_shamt = 1'b0;
    r_alu   = ALU_ADD;
    case (funct)
      6'h00: begin r_alu = ALU_SLL; r_shamt = 1'b1; end
      6'h02: begin r_alu = ALU_SRL; r_shamt = 1'b1; end
      6'h03: begin r_alu = ALU_SRA; r_shamt = 1'b1; end
      6'h04: r_alu = ALU_SLL;
      6'h20, 6'h21: r_alu = ALU_ADD;
      6'h22, 6'h23: r_alu = ALU_SUB;
      6'h24: r_alu = ALU_AND;
      6'h25: r_alu = ALU_OR;
      6'h2A: r_alu = ALU_SLT;
      6'h2B: r_alu = ALU_SLTU;
      default: r_legal = 1'b0;
    endcase
  end

  always_comb begin
    state_d       = state_q;
    pc_write      = 1'b0;
    branch        = 1'b0;
    iord          = 1'b0;
    mem_read      = 1'b0;
    mem_write     = 1'b0;
    ir_write      = 1'b0;
    reg_write     = 1'b0;
    reg_dst       = 1'b0;
    mem_to_reg    = 1'b0;
    alu_src_a     = 2'b00;
    alu_src_b     = 2'b00;
    pc_src        = 2'b00;
    alu_ctrl      = ALU_ADD;
    instr_done    = 1'b0;
    illegal_instr = 1'b0;
    case (state_q)
      S_FETCH: begin
        mem_read  = 1'b1;
        alu_src_b = 2'b01;
        ir_write  = mem_ready;
        pc_write  = mem_ready;
        if (mem_ready) state_d = S_DECODE;
      end
      S_DECODE: begin
        alu_src_b = 2'b11;
        case (opcode)
          OP_RTYPE:         state_d = r_legal ? S_EXEC_R : S_FETCH;
          OP_LW, OP_SW:     state_d = S_MEMADR;
          OP_BEQ:           state_d = S_BRANCH;
          OP_ADDI, OP_ADDIU: state_d = S_IEXEC;
          OP_J:             state_d = S_JUMP;
          default:          state_d = S_FETCH;
        endcase
        if (state_d == S_FETCH) begin
          illegal_instr = 1'b1;
          instr_done    = 1'b1;
        end
      end
      S_MEMADR: begin
        alu_src_a = 2'b01;
        alu_src_b = 2'b10;
        state_d   = (opcode == OP_SW) ? S_MEMWR : S_MEMRD;
      end
      S_MEMRD: begin
        mem_read = 1'b1;
        iord     = 1'b1;
        if (mem_ready) state_d = S_MEMWB;
      end
      S_MEMWB: begin
        reg_write  = 1'b1;
        mem_to_reg = 1'b1;
        instr_done = 1'b1;
        state_d    = S_FETCH;
      end
      S_MEMWR: begin
        mem_write  = 1'b1;
        iord       = 1'b1;
        instr_done = mem_ready;
        if (mem_ready) state_d = S_FETCH;
      end
      S_EXEC_R: begin
        alu_src_a = r_shamt ? 2'b10 : 2'b01;
        alu_ctrl  = r_alu;
        state_d   = S_ALUWB;
      end
      S_ALUWB: begin
        reg_write  = 1'b1;
        reg_dst    = 1'b1;
        instr_done = 1'b1;
        state_d    = S_FETCH;
      end
      S_BRANCH: begin
        alu_src_a  = 2'b01;
        alu_ctrl   = ALU_SUB;
        pc_src     = 2'b01;
        branch     = 1'b1;
        instr_done = 1'b1;
        state_d    = S_FETCH;
      end
      S_IEXEC: begin
        alu_src_a = 2'b01;
        alu_src_b = 2'b10;
        state_d   = S_IWB;
      end
      S_IWB: begin
        reg_write  = 1'b1;
        instr_done = 1'b1;
        state_d    = S_FETCH;
      end
      S_JUMP: begin
        pc_src     = 2'b10;
        pc_write   = 1'b1;
        instr_done = 1'b1;
        state_d    = S_FETCH;
      end
      default: state_d = S_FETCH;
    endcase
    // Reset overrides the current state, so no side effect may escape that cycle.
    if (reset) begin
      pc_write      = 1'b0;
      branch        = 1'b0;
      ir_write      = 1'b0;
      reg_write     = 1'b0;
      mem_read      = 1'b0;
      mem_write     = 1'b0;
      instr_done    = 1'b0;
      illegal_instr = 1'b0;
    end
  end

  always_ff @(posedge clk) begin
    if (reset) state_q <= S_FETCH;
    else       state_q <= state_d;
  end

  assign state_dbg = state_q;

endmodule

// File: tb/tb_mc_main_controller.sv
// Directed bench for mc_main_controller: walks each instruction class cycle by
// cycle and compares state and control outputs with hand-derived values.
module tb_mc_main_controller;

  logic       clk = 1'b0;
  logic       reset;
  logic [5:0] opcode;
  logic [5:0] funct;
  logic       mem_ready;
  logic       pc_write, branch, iord, mem_read, mem_write, ir_write;
  logic       reg_write, reg_dst, mem_to_reg, instr_done, illegal_instr;
  logic [1:0] alu_src_a, alu_src_b, pc_src;
  logic [3:0] alu_ctrl, state_dbg;

  int tests = 0;
  int fails = 0;

  mc_main_controller dut (
    .clk(clk), .reset(reset), .opcode(opcode), .funct(funct), .mem_ready(mem_ready),
    .pc_write(pc_write), .branch(branch), .iord(iord), .mem_read(mem_read),
    .mem_write(mem_write), .ir_write(ir_write), .reg_write(reg_write),
    .reg_dst(reg_dst), .mem_to_reg(mem_to_reg), .alu_src_a(alu_src_a),
    .alu_src_b(alu_src_b), .pc_src(pc_src), .alu_ctrl(alu_ctrl),
    .instr_done(instr_done), .illegal_instr(illegal_instr), .state_dbg(state_dbg)
  );

  always #5 clk = ~clk;

  // Move to the middle of the next cycle with the given mem_ready applied.
  task automatic tick(input logic ready);
    @(negedge clk);
    mem_ready = ready;
    #1;
  endtask

  task automatic test_reset();
    reset = 1'b1; opcode = 6'h00; funct = 6'h20; mem_ready = 1'b1;
    repeat (2) tick(1'b1);
    tests++;
    if (state_dbg !== 4'd0) begin $display("FAIL reset_state got %0d want 0", state_dbg); fails++; end
    tests++;
    if ({pc_write, branch, ir_write, reg_write, mem_read, mem_write, instr_done, illegal_instr} !== 8'h00) begin
      $display("FAIL reset_strobes got %b want 00000000",
               {pc_write, branch, ir_write, reg_write, mem_read, mem_write, instr_done, illegal_instr});
      fails++;
    end
    @(negedge clk); reset = 1'b0; mem_ready = 1'b0; #1;
    tests++;
    if (state_dbg !== 4'd0 || mem_read !== 1'b1) begin
      $display("FAIL reset_release got state %0d mem_read %b want 0/1", state_dbg, mem_read); fails++;
    end
    tests++;
    if (ir_write !== 1'b0 || pc_write !== 1'b0) begin
      $display("FAIL fetch_wait got ir_write %b pc_write %b want 0/0", ir_write, pc_write); fails++;
    end
    $display("[TB] reset transaction");
  endtask

  task automatic test_add();
    int exp_s[4];
    int done_cnt = 0;
    exp_s = '{0, 1, 6, 7};
    opcode = 6'h00; funct = 6'h20;
    for (int i = 0; i < 4; i++) begin
      tick(1'b1);
      tests++;
      if (state_dbg !== 4'(exp_s[i])) begin $display("FAIL add_state[%0d] got %0d want %0d", i, state_dbg, exp_s[i]); fails++; end
      tests++;
      if (reg_write !== (i == 3) || reg_dst !== (i == 3)) begin
        $display("FAIL add_wb[%0d] got reg_write %b reg_dst %b want %b", i, reg_write, reg_dst, (i == 3)); fails++;
      end
      if (i == 0) begin
        tests++;
        if (ir_write !== 1'b1 || pc_write !== 1'b1 || alu_src_b !== 2'b01) begin
          $display("FAIL add_fetch got ir_write %b pc_write %b src_b %b want 1/1/01", ir_write, pc_write, alu_src_b); fails++;
        end
      end
      if (i == 1) begin
        tests++;
        if (alu_src_b !== 2'b11 || alu_ctrl !== 4'd0) begin
          $display("FAIL add_decode got src_b %b alu %0d want 11/0", alu_src_b, alu_ctrl); fails++;
        end
      end
      done_cnt += int'(instr_done);
    end
    tests++;
    if (done_cnt != 1) begin $display("FAIL add_done_count got %0d want 1", done_cnt); fails++; end
    $display("[TB] add transaction");
  endtask

  task automatic test_lw_wait();
    int exp_s[7];
    logic rdy[7];
    int rw_cnt = 0;
    exp_s = '{0, 1, 2, 3, 3, 3, 4};
    rdy   = '{1'b1, 1'b1, 1'b1, 1'b0, 1'b0, 1'b1, 1'b1};
    opcode = 6'h23;
    for (int i = 0; i < 7; i++) begin
      tick(rdy[i]);
      tests++;
      if (state_dbg !== 4'(exp_s[i])) begin $display("FAIL lw_state[%0d] got %0d want %0d", i, state_dbg, exp_s[i]); fails++; end
      rw_cnt += int'(reg_write);
      if (i == 2) begin
        tests++;
        if (alu_src_a !== 2'b01 || alu_src_b !== 2'b10) begin
          $display("FAIL lw_memadr got src_a %b src_b %b want 01/10", alu_src_a, alu_src_b); fails++;
        end
      end
      if (i >= 3 && i <= 5) begin
        tests++;
        if (mem_read !== 1'b1 || iord !== 1'b1) begin
          $display("FAIL lw_memrd[%0d] got mem_read %b iord %b want 1/1", i, mem_read, iord); fails++;
        end
      end
      if (i == 6) begin
        tests++;
        if (mem_to_reg !== 1'b1 || reg_dst !== 1'b0 || instr_done !== 1'b1) begin
          $display("FAIL lw_memwb got mem_to_reg %b reg_dst %b done %b want 1/0/1", mem_to_reg, reg_dst, instr_done); fails++;
        end
      end
    end
    tests++;
    if (rw_cnt != 1) begin $display("FAIL lw_reg_write_count got %0d want 1", rw_cnt); fails++; end
    $display("[TB] lw transaction with memory wait");
  endtask

  task automatic test_shift();
    logic [5:0] f[3];
    logic [1:0] exp_a[3];
    logic [3:0] exp_alu[3];
    f = '{6'h00, 6'h04, 6'h03};
    exp_a = '{2'b10, 2'b01, 2'b10};
    exp_alu = '{4'd4, 4'd4, 4'd6};
    opcode = 6'h00;
    for (int k = 0; k < 3; k++) begin
      funct = f[k];
      for (int i = 0; i < 4; i++) begin
        tick(1'b1);
        if (i == 2) begin
          tests++;
          if (state_dbg !== 4'd6 || alu_src_a !== exp_a[k] || alu_ctrl !== exp_alu[k] || alu_src_b !== 2'b00) begin
            $display("FAIL shift_exec funct %h got state %0d src_a %b alu %0d src_b %b want 6/%b/%0d/00",
                     f[k], state_dbg, alu_src_a, alu_ctrl, alu_src_b, exp_a[k], exp_alu[k]);
            fails++;
          end
        end
      end
      $display("[TB] shift transaction funct %h", f[k]);
    end
  endtask

  task automatic test_addi();
    int exp_s[4];
    exp_s = '{0, 1, 9, 10};
    opcode = 6'h08;
    for (int i = 0; i < 4; i++) begin
      tick(1'b1);
      tests++;
      if (state_dbg !== 4'(exp_s[i])) begin $display("FAIL addi_state[%0d] got %0d want %0d", i, state_dbg, exp_s[i]); fails++; end
      if (i == 2) begin
        tests++;
        if (alu_src_a !== 2'b01 || alu_src_b !== 2'b10 || alu_ctrl !== 4'd0) begin
          $display("FAIL addi_exec got src_a %b src_b %b alu %0d want 01/10/0", alu_src_a, alu_src_b, alu_ctrl); fails++;
        end
      end
      if (i == 3) begin
        tests++;
        if (reg_write !== 1'b1 || reg_dst !== 1'b0 || mem_to_reg !== 1'b0 || instr_done !== 1'b1) begin
          $display("FAIL addi_wb got rw %b dst %b m2r %b done %b want 1/0/0/1", reg_write, reg_dst, mem_to_reg, instr_done); fails++;
        end
      end
    end
    $display("[TB] addi transaction");
  endtask

  task automatic test_illegal();
    logic [5:0] ops[2];
    logic [5:0] fns[2];
    ops = '{6'h3F, 6'h00};
    fns = '{6'h20, 6'h3F};
    for (int k = 0; k < 2; k++) begin
      opcode = ops[k]; funct = fns[k];
      tick(1'b1);
      tick(1'b1);
      tests++;
      if (state_dbg !== 4'd1 || illegal_instr !== 1'b1 || instr_done !== 1'b1) begin
        $display("FAIL illegal_decode op %h fn %h got state %0d ill %b done %b want 1/1/1",
                 ops[k], fns[k], state_dbg, illegal_instr, instr_done);
        fails++;
      end
      tests++;
      if ({reg_write, mem_write, pc_write, ir_write, branch} !== 5'b0) begin
        $display("FAIL illegal_strobes got %b want 00000", {reg_write, mem_write, pc_write, ir_write, branch}); fails++;
      end
      tick(1'b0);
      tests++;
      if (state_dbg !== 4'd0 || illegal_instr !== 1'b0) begin
        $display("FAIL illegal_next got state %0d ill %b want 0/0", state_dbg, illegal_instr); fails++;
      end
      $display("[TB] illegal transaction op %h funct %h", ops[k], fns[k]);
    end
  endtask

  task automatic test_sw_reset();
    opcode = 6'h2B;
    for (int i = 0; i < 4; i++) tick(1'b1);
    tests++;
    if (state_dbg !== 4'd5 || mem_write !== 1'b1 || iord !== 1'b1 || instr_done !== 1'b1) begin
      $display("FAIL sw_memwr got state %0d mem_write %b iord %b done %b want 5/1/1/1", state_dbg, mem_write, iord, instr_done); fails++;
    end
    $display("[TB] sw transaction");
    for (int i = 0; i < 3; i++) tick(1'b1);
    @(negedge clk); mem_ready = 1'b1; reset = 1'b1; #1;
    tests++;
    if (state_dbg !== 4'd5 || mem_write !== 1'b0 || instr_done !== 1'b0) begin
      $display("FAIL sw_reset_cycle got state %0d mem_write %b done %b want 5/0/0", state_dbg, mem_write, instr_done); fails++;
    end
    @(negedge clk); reset = 1'b0; mem_ready = 1'b0; #1;
    tests++;
    if (state_dbg !== 4'd0) begin $display("FAIL sw_reset_next got state %0d want 0", state_dbg); fails++; end
    $display("[TB] sw transaction aborted by reset");
  endtask

  task automatic test_back_to_back();
    int exp_s[6];
    int done_cnt = 0;
    exp_s = '{0, 1, 8, 0, 1, 11};
    opcode = 6'h04;
    for (int i = 0; i < 6; i++) begin
      if (i == 3) opcode = 6'h02;
      tick(1'b1);
      tests++;
      if (state_dbg !== 4'(exp_s[i])) begin $display("FAIL b2b_state[%0d] got %0d want %0d", i, state_dbg, exp_s[i]); fails++; end
      done_cnt += int'(instr_done);
      if (i == 2) begin
        tests++;
        if (branch !== 1'b1 || pc_src !== 2'b01 || alu_ctrl !== 4'd1 || alu_src_a !== 2'b01 || pc_write !== 1'b0) begin
          $display("FAIL beq_ctrl got branch %b pc_src %b alu %0d src_a %b pc_write %b want 1/01/1/01/0",
                   branch, pc_src, alu_ctrl, alu_src_a, pc_write);
          fails++;
        end
      end
      if (i == 5) begin
        tests++;
        if (pc_write !== 1'b1 || pc_src !== 2'b10 || branch !== 1'b0) begin
          $display("FAIL j_ctrl got pc_write %b pc_src %b branch %b want 1/10/0", pc_write, pc_src, branch); fails++;
        end
      end
    end
    tick(1'b0);
    tests++;
    if (state_dbg !== 4'd0 || done_cnt != 2) begin
      $display("FAIL b2b_end got state %0d done_count %0d want 0/2", state_dbg, done_cnt); fails++;
    end
    $display("[TB] beq then j transaction");
  endtask

  initial begin
    test_reset();
    test_add();
    test_lw_wait();
    test_shift();
    test_addi();
    test_illegal();
    test_sw_reset();
    test_back_to_back();
    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule

// File: doc/mc_main_controller.md
MC_MAIN_CONTROLLER -- requirements
Module: mc_main_controller

Interface
REQ-001 The block SHALL have no parameters; it is the sequencing FSM plus ALU decoder for the multi-cycle MIPS datapath.
REQ-002 clk  input  1  sole clock; all state changes on rising edge.
REQ-003 reset  input  1  synchronous, active-high.
REQ-004 opcode  input  6  IR[31:26]; valid from DECODE onward.
REQ-005 funct  input  6  IR[5:0]; valid from DECODE onward.
REQ-006 mem_ready  input  1  unified memory completes the current access this cycle.
REQ-007 pc_write  output  1  unconditional PC load.
REQ-008 branch  output  1  PC load qualified by ALU zero.
REQ-009 iord  output  1  memory address: 0=PC, 1=ALUOut.
REQ-010 mem_read  output  1  memory read request.
REQ-011 mem_write  output  1  memory write request.
REQ-012 ir_write  output  1  IR load.
REQ-013 reg_write  output  1  register file write.
REQ-014 reg_dst  output  1  write register: 0=rt, 1=rd.
REQ-015 mem_to_reg  output  1  write data: 0=ALUOut, 1=MDR.
REQ-016 alu_src_a  output  2  00=PC, 01=A, 10=zero-extended shamt.
REQ-017 alu_src_b  output  2  00=B, 01=4, 10=sext(imm), 11=sext(imm)<<2.
REQ-018 pc_src  output  2  00=ALU result, 01=ALUOut, 10=jump target.
REQ-019 alu_ctrl  output  4  0=ADD,1=SUB,2=SLT,3=SLTU,4=SLL,5=SRL,6=SRA,7=AND,8=OR; shifts apply to operand B by operand A[4:0].
REQ-020 instr_done  output  1  one-cycle pulse in the last cycle of each instruction.
REQ-021 illegal_instr  output  1  one-cycle pulse in DECODE for an unsupported encoding.
REQ-022 state_dbg  output  4  current state encoding.

Function
REQ-023 The states SHALL be encoded FETCH=0, DECODE=1, MEMADR=2, MEMRD=3, MEMWB=4, MEMWR=5, EXEC_R=6, ALUWB=7, BRANCH=8, IEXEC=9, IWB=10, JUMP=11; codes 12-15 SHALL go to FETCH.
REQ-024 Supported set: R-type (opcode 00) with funct sll 00, srl 02, sra 03, sllv 04, add 20, addu 21, sub 22, subu 23, and 24, or 25, slt 2A, sltu 2B; j 02, beq 04, addi 08, addiu 09, lw 23, sw 2B (all hex).
REQ-025 Controls not listed for a state SHALL be 0; alu_ctrl SHALL default to ADD.
REQ-026 FETCH: mem_read=1, iord=0, src_a=00, src_b=01, ADD; ir_write=pc_write=mem_ready; hold FETCH until mem_ready, then DECODE.
REQ-027 DECODE: src_a=00, src_b=11, ADD; next state by opcode: lw/sw->MEMADR, R->EXEC_R, beq->BRANCH, addi/addiu->IEXEC, j->JUMP; unsupported opcode/funct->FETCH with illegal_instr=1 and instr_done=1.
REQ-028 MEMADR: src_a=01, src_b=10, ADD; lw->MEMRD, sw->MEMWR.
REQ-029 MEMRD: mem_read=1, iord=1; hold until mem_ready, then MEMWB.
REQ-030 MEMWB: reg_write=1, reg_dst=0, mem_to_reg=1, instr_done=1; ->FETCH.
REQ-031 MEMWR: mem_write=1, iord=1; hold until mem_ready; instr_done=mem_ready; then FETCH.
REQ-032 EXEC_R: src_b=00; src_a=10 for sll/srl/sra, else 01; alu_ctrl from funct (add/addu ADD, sub/subu SUB, sllv SLL); ->ALUWB.
REQ-033 ALUWB: reg_write=1, reg_dst=1, mem_to_reg=0, instr_done=1; ->FETCH.
REQ-034 BRANCH: src_a=01, src_b=00, SUB, pc_src=01, branch=1, instr_done=1; ->FETCH.
REQ-035 IEXEC: src_a=01, src_b=10, ADD; ->IWB. IWB: reg_write=1, reg_dst=0, mem_to_reg=0, instr_done=1; ->FETCH.
REQ-036 JUMP: pc_src=10, pc_write=1, instr_done=1; ->FETCH.
REQ-037 Latency with mem_ready tied high: lw 5, sw/R/addi/addiu 4, beq/j 3, illegal 2 cycles.

Reset
REQ-038 A cycle with reset=1 SHALL load FETCH, regardless of current state or pending mem_ready.
REQ-039 While reset=1, pc_write, branch, ir_write, reg_write, mem_read, mem_write, instr_done and illegal_instr SHALL be 0.
REQ-040 The first cycle after reset deasserts SHALL be FETCH with mem_read=1.

Verification
REQ-041 mem_ready=1, opcode 00 funct 20 -> states 0,1,6,7; reg_write=1 and reg_dst=1 in state 7 only; instr_done pulses once.
REQ-042 lw (23), mem_ready low 2 cycles in MEMRD -> MEMRD held 3 cycles, single reg_write with mem_to_reg=1, 7 cycles total.
REQ-043 sll (funct 00) -> EXEC_R drives src_a=10, alu_ctrl=4; sllv (funct 04) -> src_a=01, alu_ctrl=4.
REQ-044 opcode 3F -> illegal_instr=1 in DECODE, no write strobes, FETCH next cycle.
REQ-045 reset=1 asserted in MEMWR with mem_ready=1 -> no mem_write that cycle, state_dbg=0 next cycle.
REQ-046 beq (04) then j (02) -> branch=1 with pc_src=01, then pc_write=1 with pc_src=10; 6 cycles total.
